// File: rtl/ysyx_22051013_id_issue_pkg.sv
// Shared constants for the ysyx_22051013 ID/issue stage.
//   REG_AW   : architectural register address width
//   REG_ZERO : x0 address
//   br_op_e  : branch-op encoding carried on in_br_op
//   PC_STEP  : fall-through increment for a not-taken branch
package ysyx_22051013_id_issue_pkg;

    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] REG_ZERO = '0;
    localparam int PC_STEP = 4;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLT  = 3'd3,
        BR_BGE  = 3'd4,
        BR_BLTU = 3'd5,
        BR_BGEU = 3'd6,
        BR_JALR = 3'd7
    } br_op_e;

endpackage

// File: rtl/ysyx_22051013_id_scoreboard.sv
// Load-use scoreboard: one pending bit per architectural register.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   i_set_en / i_set_addr   : mark a register pending (load left ID)
//   i_clr_en / i_clr_addr   : clear a pending register (load wrote back)
//   i_q1_addr / o_q1_pend   : query port for source 1
//   i_q2_addr / o_q2_pend   : query port for source 2
// A set and a clear on the same register in one cycle leaves it pending.
module ysyx_22051013_id_scoreboard
    import ysyx_22051013_id_issue_pkg::*;
#(
    parameter int SB_REGS = 32
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_set_en,
    input  logic [REG_AW-1:0] i_set_addr,
    input  logic              i_clr_en,
    input  logic [REG_AW-1:0] i_clr_addr,
    input  logic [REG_AW-1:0] i_q1_addr,
    input  logic [REG_AW-1:0] i_q2_addr,
    output logic              o_q1_pend,
    output logic              o_q2_pend
);

    logic [SB_REGS-1:0] r_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            for (int i = 0; i < SB_REGS; i++) begin
                if (i_set_en && i_set_addr == REG_AW'(i))
                    r_pend[i] <= 1'b1;
                else if (i_clr_en && i_clr_addr == REG_AW'(i))
                    r_pend[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        o_q1_pend = 1'b0;
        o_q2_pend = 1'b0;
        for (int i = 0; i < SB_REGS; i++) begin
            if (i_q1_addr == REG_AW'(i)) o_q1_pend = r_pend[i];
            if (i_q2_addr == REG_AW'(i)) o_q2_pend = r_pend[i];
        end
    end

endmodule

// File: rtl/ysyx_22051013_id_issue.sv
// ID/issue stage: regfile read, operand forwarding, load-use stall via a
// scoreboard, a single output register toward EX, and optional branch
// resolution with a one-cycle redirect pulse.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   in_valid/in_ready              : IF-side handshake
//   in_pc..in_bpu_jump             : decoded instruction fields
//   rs1_addr/rs2_addr, rs*_data    : regfile read (same-cycle data)
//   fwd_valid/fwd_addr/fwd_data    : NFWD bypass sources, index 0 youngest
//   ld_wb_valid/ld_wb_addr         : load writeback, clears pending bit
//   flush                          : squash from a later stage
//   out_valid/ex_ready, out_*      : EX-side handshake and payload
//   redirect/redirect_pc           : mispredict / JALR redirect
// Build option: define YSYX_22051013_ID_BRANCH_RESOLVE_EN to enable branch
// resolution; otherwise redirect and redirect_pc are tied to 0.
module ysyx_22051013_id_issue
    import ysyx_22051013_id_issue_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int NFWD    = 3,
    parameter int SB_REGS = 32
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [XLEN-1:0]        in_imm,
    input  logic [REG_AW-1:0]      in_rs1,
    input  logic [REG_AW-1:0]      in_rs2,
    input  logic [REG_AW-1:0]      in_rd,
    input  logic                   in_rs1_ena,
    input  logic                   in_rs2_ena,
    input  logic                   in_rd_ena,
    input  logic                   in_load,
    input  logic [2:0]             in_br_op,
    input  logic                   in_bpu_jump,
    output logic [REG_AW-1:0]      rs1_addr,
    output logic [REG_AW-1:0]      rs2_addr,
    input  logic [XLEN-1:0]        rs1_data,
    input  logic [XLEN-1:0]        rs2_data,
    input  logic [NFWD-1:0]        fwd_valid,
    input  logic [NFWD*REG_AW-1:0] fwd_addr,
    input  logic [NFWD*XLEN-1:0]   fwd_data,
    input  logic                   ld_wb_valid,
    input  logic [REG_AW-1:0]      ld_wb_addr,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   ex_ready,
    output logic [XLEN-1:0]        out_op1,
    output logic [XLEN-1:0]        out_op2,
    output logic [XLEN-1:0]        out_pc,
    output logic [XLEN-1:0]        out_imm,
    output logic [REG_AW-1:0]      out_rd,
    output logic                   out_rd_ena,
    output logic                   out_load,
    output logic                   redirect,
    output logic [XLEN-1:0]        redirect_pc
);

    // Returns {hit, value}. x0 always reads 0 and never counts as a forward
    // hit; among bypass sources the lowest index (youngest) wins.
    function automatic logic [XLEN:0] f_resolve(
        input logic [REG_AW-1:0]      addr,
        input logic [XLEN-1:0]        rf,
        input logic [NFWD-1:0]        v,
        input logic [NFWD*REG_AW-1:0] fa,
        input logic [NFWD*XLEN-1:0]   fd
    );
        logic [XLEN:0] res;
        res = {1'b0, rf};
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (v[i] && fa[i*REG_AW +: REG_AW] == addr)
                res = {1'b1, fd[i*XLEN +: XLEN]};
        end
        if (addr == REG_ZERO) res = '0;
        return res;
    endfunction

    logic              r_out_valid, r_out_rd_ena, r_out_load;
    logic [XLEN-1:0]   r_out_op1, r_out_op2, r_out_pc, r_out_imm;
    logic [REG_AW-1:0] r_out_rd;

    logic [XLEN-1:0] w_op1, w_op2;
    logic            w_fwd1, w_fwd2, w_pend1, w_pend2;
    logic            w_held_ld, w_busy1, w_busy2, w_stall;
    logic            w_accept, w_fire_out, w_sb_set, w_redirect;

    assign rs1_addr = in_rs1_ena ? in_rs1 : REG_ZERO;
    assign rs2_addr = in_rs2_ena ? in_rs2 : REG_ZERO;

    assign {w_fwd1, w_op1} = f_resolve(rs1_addr, rs1_data, fwd_valid, fwd_addr, fwd_data);
    assign {w_fwd2, w_op2} = f_resolve(rs2_addr, rs2_data, fwd_valid, fwd_addr, fwd_data);

    // A load still sitting in the output register has not reached the
    // scoreboard yet, so its rd is checked directly.
    assign w_held_ld = r_out_valid & r_out_load & r_out_rd_ena;
    assign w_busy1   = (rs1_addr != REG_ZERO) & ~w_fwd1 &
                       (w_pend1 | (w_held_ld & (r_out_rd == rs1_addr)));
    assign w_busy2   = (rs2_addr != REG_ZERO) & ~w_fwd2 &
                       (w_pend2 | (w_held_ld & (r_out_rd == rs2_addr)));
    assign w_stall   = w_busy1 | w_busy2;

    // flush and rst also drop in_ready so IF never sees a handshake that
    // was not taken.
    assign in_ready   = ~rst & ~flush & ~w_stall & (~r_out_valid | ex_ready) & ~w_redirect;
    assign w_accept   = in_valid & in_ready;
    // A flushed instruction never counts as fired, so it cannot mark its rd.
    assign w_fire_out = r_out_valid & ex_ready & ~flush;
    assign w_sb_set   = w_fire_out & r_out_load & r_out_rd_ena & (r_out_rd != REG_ZERO);

    // Writeback clears keep working during flush: they come from older
    // instructions that are not being squashed.
    ysyx_22051013_id_scoreboard #(.SB_REGS(SB_REGS)) u_sb (
        .clk        (clk),
        .rst        (rst),
        .i_set_en   (w_sb_set),
        .i_set_addr (r_out_rd),
        .i_clr_en   (ld_wb_valid),
        .i_clr_addr (ld_wb_addr),
        .i_q1_addr  (rs1_addr),
        .i_q2_addr  (rs2_addr),
        .o_q1_pend  (w_pend1),
        .o_q2_pend  (w_pend2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_op1    <= '0;
            r_out_op2    <= '0;
            r_out_pc     <= '0;
            r_out_imm    <= '0;
            r_out_rd     <= '0;
            r_out_rd_ena <= 1'b0;
            r_out_load   <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_out_op1    <= w_op1;
            r_out_op2    <= w_op2;
            r_out_pc     <= in_pc;
            r_out_imm    <= in_imm;
            r_out_rd     <= in_rd;
            r_out_rd_ena <= in_rd_ena;
            r_out_load   <= in_load;
        end else if (ex_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_op1    = r_out_op1;
    assign out_op2    = r_out_op2;
    assign out_pc     = r_out_pc;
    assign out_imm    = r_out_imm;
    assign out_rd     = r_out_rd;
    assign out_rd_ena = r_out_rd_ena;
    assign out_load   = r_out_load;

`ifdef YSYX_22051013_ID_BRANCH_RESOLVE_EN
    localparam logic [XLEN-1:0] W_STEP = XLEN'(PC_STEP);
    localparam logic [XLEN-1:0] W_LSB0 = ~XLEN'(1);

    logic            w_taken, w_need;
    logic [XLEN-1:0] w_target;
    logic            r_redirect;
    logic [XLEN-1:0] r_redirect_pc;

    always_comb begin
        w_taken = 1'b0;
        case (br_op_e'(in_br_op))
            BR_BEQ:  w_taken = (w_op1 == w_op2);
            BR_BNE:  w_taken = (w_op1 != w_op2);
            BR_BLT:  w_taken = ($signed(w_op1) <  $signed(w_op2));
            BR_BGE:  w_taken = ($signed(w_op1) >= $signed(w_op2));
            BR_BLTU: w_taken = (w_op1 <  w_op2);
            BR_BGEU: w_taken = (w_op1 >= w_op2);
            default: w_taken = 1'b0;
        endcase
        w_need   = 1'b0;
        w_target = '0;
        if (br_op_e'(in_br_op) == BR_JALR) begin
            w_need   = 1'b1;
            w_target = (w_op1 + in_imm) & W_LSB0;
        end else if (br_op_e'(in_br_op) != BR_NONE && w_taken != in_bpu_jump) begin
            // Only a disagreement with the predictor needs a redirect.
            w_need   = 1'b1;
            w_target = w_taken ? (in_pc + in_imm) : (in_pc + W_STEP);
        end
    end

    // w_accept already excludes flush, so a flushed cycle never redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
        end else if (w_accept && w_need) begin
            r_redirect    <= 1'b1;
            r_redirect_pc <= w_target;
        end else begin
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
        end
    end

    assign w_redirect  = r_redirect;
    assign redirect    = r_redirect;
    assign redirect_pc = r_redirect_pc;
`else
    logic w_unused_br;
    assign w_unused_br = ^{in_br_op, in_bpu_jump};
    assign w_redirect  = 1'b0;
    assign redirect    = 1'b0;
    assign redirect_pc = '0;
`endif

endmodule

// File: doc/ysyx_22051013_id_issue.md
YSYX_22051013_ID_ISSUE -- requirements
Module: ysyx_22051013_id_issue

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width.
REQ-002 SHALL have parameter NFWD, default 3, forwarding source count; index 0 is the youngest stage.
REQ-003 SHALL have parameter SB_REGS, default 32, scoreboard entries (register count).
REQ-004 SHALL have ports: clk in 1, clock; rst in 1, reset; one clock domain; reset is synchronous and active-high.
REQ-005 SHALL have ports: in_valid in 1 / in_ready out 1, the IF-side handshake.
REQ-006 SHALL have ports: in_pc in XLEN; in_imm in XLEN; in_rs1, in_rs2, in_rd in 5 each; in_rs1_ena, in_rs2_ena, in_rd_ena, in_load in 1 each; in_br_op in 3; in_bpu_jump in 1.
REQ-007 SHALL have ports: rs1_addr, rs2_addr out 5; rs1_data, rs2_data in XLEN; these are regfile reads, data valid in the same cycle.
REQ-008 SHALL have ports: fwd_valid in NFWD; fwd_addr in NFWD*5; fwd_data in NFWD*XLEN.
REQ-009 SHALL have ports: ld_wb_valid in 1, ld_wb_addr in 5, the load-writeback retire signal.
REQ-010 SHALL have ports: flush in 1, flush from a later stage.
REQ-011 SHALL have ports: out_valid out 1 / ex_ready in 1; out_op1, out_op2, out_pc, out_imm out XLEN; out_rd out 5; out_rd_ena, out_load out 1.
REQ-012 SHALL have ports: redirect out 1; redirect_pc out XLEN.

Function
REQ-013 SHALL drive rs1_addr/rs2_addr with in_rsN when in_rsN_ena is set, else 0.
REQ-014 SHALL resolve each operand in this priority: x0 gives 0; then the lowest-index fwd source with fwd_valid set and a matching address; then regfile data.
REQ-015 SHALL keep a scoreboard with one pending bit per register. A bit is set when a load with rd!=0 fires out (out_valid & ex_ready). It is cleared by ld_wb_valid at ld_wb_addr. If set and clear land on the same register in the same cycle, set wins.
REQ-016 SHALL stall (in_ready=0) when an enabled source hits a pending bit or hits out_rd of a load held in the output register, unless a fwd source matches with fwd_valid set.
REQ-017 SHALL set in_ready = ~stall & (~out_valid | ex_ready) & ~redirect.
REQ-018 SHALL load the output register on in_valid & in_ready, with zero added latency; it holds all outputs stable while out_valid & ~ex_ready.
REQ-019 SHALL, when flush is asserted, clear out_valid next cycle, accept nothing that cycle, and leave the scoreboard unchanged.
REQ-020 SHALL encode in_br_op as: 0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 JALR. Signed compares are done at full XLEN.
REQ-021 SHALL compute redirect (registered, one-cycle pulse after accept):
- JALR: always, target (op1+imm) with bit0 cleared.
- Branch with taken != in_bpu_jump: target pc+imm if taken, else pc+4.
REQ-022 SHALL hold redirect_pc at 0 when redirect=0. Redirect is suppressed if flush is asserted in the same cycle.

Reset
REQ-023 SHALL on rst clear out_valid, redirect, all scoreboard bits and all output data registers to 0. rst overrides flush and handshakes; in_ready=0 during rst.

Configuration
REQ-024 SHALL use macro YSYX_22051013_ID_BRANCH_RESOLVE_EN.
- Defined: REQ-020..022 active.
- Undefined: redirect and redirect_pc tied 0, no comparator logic, in_br_op ignored.

Structure
REQ-025 SHALL place br_op encodings, reg-address width (5) and zero constants in the shared define file alongside the existing ysyx_22051013 macros.
REQ-026 SHALL implement the scoreboard as sub-module ysyx_22051013_id_scoreboard (set/clear/query ports); the forwarding mux stays inline.

Verification
REQ-027 ADD x3 with fwd_valid[1]=1, fwd_addr[1]=3, fwd_data[1]=0x55 and x3 regfile=0x11 -> out_op1=0x55 the next cycle.
REQ-028 LD x5 fires, then ADD x6,x5,x0 with no forward -> in_ready=0 until ld_wb_valid with addr 5, then accepted the following cycle.
REQ-029 BEQ with op1=op2=7, in_bpu_jump=0, pc=0x80000000, imm=0x10 -> redirect=1 for one cycle with redirect_pc=0x80000010.
REQ-030 JALR with op1=0x80001003, imm=4 -> redirect_pc=0x80001006.
REQ-031 out_valid held with ex_ready=0 for 3 cycles -> outputs stable; flush -> out_valid=0 next cycle, scoreboard unchanged.
REQ-032 rst asserted mid-stall with pending bit x5 set -> all outputs 0, x5 no longer blocks.
